// File: rtl/dsss_spread_mod_if.sv
// Purpose: bit-in / sample-out bundle for the DSSS BPSK spreader.
// Latency: n/a (signal bundle only).
// Backpressure: din is offered with din_valid/din_ready; the carrier and output sample streams have no backpressure.
// Ports: din_valid/din/din_ready (data bit handshake), car_valid/car_sin (nco carrier),
//        dout_valid/dout/chip_o/sym_start (spread-modulated output stream).
interface dsss_spread_mod_if;
    logic              din_valid;
    logic              din;
    logic              din_ready;
    logic              car_valid;
    logic signed [9:0] car_sin;
    logic              dout_valid;
    logic signed [9:0] dout;
    logic              chip_o;
    logic              sym_start;

    // master: bit source plus carrier source plus sample sink (harness side)
    modport master (
        output din_valid, din, car_valid, car_sin,
        input  din_ready, dout_valid, dout, chip_o, sym_start
    );

    // slave: the spreader itself
    modport slave (
        input  din_valid, din, car_valid, car_sin,
        output din_ready, dout_valid, dout, chip_o, sym_start
    );
endinterface

// File: rtl/dsss_spread_mod.sv
// Purpose: spreads one data bit per symbol with a (2^PN_W-1)-chip m-sequence and BPSK-modulates nco carrier samples.
// Latency: 1 cycle from an accepted carrier sample (car_valid & clken) to dout/dout_valid/chip_o.
// Backpressure: din_ready is high in IDLE and only on the last sample of a symbol in RUN; carrier is never stalled.
// Ports: clk, reset_n (synchronous, active-low), clken (global enable),
//        sp (dsss_spread_mod_if.slave): din handshake in, carrier samples in, modulated samples out.
module dsss_spread_mod #(
    parameter int             SPC  = 4,
    parameter int             PN_W = 5,
    parameter logic [PN_W-1:0] POLY = 5'b00101,
    parameter logic [PN_W-1:0] SEED = 5'b00001
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clken,
    dsss_spread_mod_if.slave         sp
);

    localparam int SAMP_W = (SPC > 1) ? $clog2(SPC) : 1;
    localparam int CHIPS  = (1 << PN_W) - 1;

    localparam logic signed [9:0] CAR_MIN = 10'sh200;   // -512
    localparam logic signed [9:0] CAR_MAX = 10'sh1ff;   // +511

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nx;
    logic [PN_W-1:0]   lfsr, lfsr_nx;
    logic [SAMP_W-1:0] samp_cnt, samp_nx;
    logic [PN_W-1:0]   chip_cnt, chip_nx;
    logic              bit_r, bit_nx;
    logic              dvalid_r, dvalid_nx;
    logic signed [9:0] dout_r, dout_nx;
    logic              chip_r, chip_nx_o;
    logic              sym_r, sym_nx;

    logic              adv;
    logic              samp_last;
    logic              chip_last;
    logic              sym_end;
    logic              ready;
    logic              xfer;
    logic [PN_W-1:0]   lfsr_step;
    logic signed [9:0] neg_sin;

    assign adv       = sp.car_valid & clken;
    assign samp_last = (samp_cnt == SAMP_W'(SPC - 1));
    assign chip_last = (chip_cnt == PN_W'(CHIPS - 1));
    assign sym_end   = samp_last & chip_last;

    // In RUN the next bit may only be taken on the very sample that closes the
    // symbol, so the new symbol starts on the following valid sample with no gap.
    assign ready = (state == IDLE) | (adv & sym_end);
    assign xfer  = sp.din_valid & ready & clken;

    assign lfsr_step = {^(lfsr & POLY), lfsr[PN_W-1:1]};

    // Negating the most negative sample would wrap; clamp it to full scale.
    assign neg_sin = (sp.car_sin == CAR_MIN) ? CAR_MAX : -sp.car_sin;

    always_comb begin
        state_nx  = state;
        lfsr_nx   = lfsr;
        samp_nx   = samp_cnt;
        chip_nx   = chip_cnt;
        bit_nx    = bit_r;
        dvalid_nx = adv;
        dout_nx   = dout_r;
        chip_nx_o = chip_r;
        sym_nx    = 1'b0;

        case (state)
            IDLE: begin
                if (adv) begin
                    dout_nx   = '0;
                    chip_nx_o = 1'b0;
                end
                if (xfer) begin
                    bit_nx   = sp.din;
                    lfsr_nx  = SEED;
                    samp_nx  = '0;
                    chip_nx  = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (adv) begin
                    dout_nx   = (bit_r ^ lfsr[0]) ? neg_sin : sp.car_sin;
                    chip_nx_o = lfsr[0];
                    sym_nx    = (samp_cnt == '0) && (chip_cnt == '0);
                    if (sym_end) begin
                        // Counters and LFSR are rearmed either way; only the
                        // state depends on whether a new bit arrived.
                        lfsr_nx = SEED;
                        samp_nx = '0;
                        chip_nx = '0;
                        if (xfer) begin
                            bit_nx = sp.din;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else if (samp_last) begin
                        samp_nx = '0;
                        lfsr_nx = lfsr_step;
                        chip_nx = chip_cnt + 1'b1;
                    end else begin
                        samp_nx = samp_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            lfsr     <= SEED;
            samp_cnt <= '0;
            chip_cnt <= '0;
            bit_r    <= 1'b0;
            dvalid_r <= 1'b0;
            dout_r   <= '0;
            chip_r   <= 1'b0;
            sym_r    <= 1'b0;
        end else begin
            state    <= state_nx;
            lfsr     <= lfsr_nx;
            samp_cnt <= samp_nx;
            chip_cnt <= chip_nx;
            bit_r    <= bit_nx;
            dvalid_r <= dvalid_nx;
            dout_r   <= dout_nx;
            chip_r   <= chip_nx_o;
            sym_r    <= sym_nx;
        end
    end

    assign sp.din_ready  = ready;
    assign sp.dout_valid = dvalid_r;
    assign sp.dout       = dout_r;
    assign sp.chip_o     = chip_r;
    assign sp.sym_start  = sym_r;

endmodule

// File: tb/tb_dsss_spread_mod.sv
module tb_dsss_spread_mod;

    localparam int SPC   = 4;
    localparam int PN_W  = 5;
    localparam int NCHIP = 31;
    localparam int NS    = NCHIP * SPC;   // samples per symbol

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clken = 1'b0;

    dsss_spread_mod_if bus();

    dsss_spread_mod #(
        .SPC (SPC),
        .PN_W(PN_W),
        .POLY(5'b00101),
        .SEED(5'b00001)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .clken  (clken),
        .sp     (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic pn [NCHIP];
    logic m_idle;
    int   m_pos;
    logic m_bit;
    logic exp_rdy;
    logic e_dv;
    logic signed [9:0] e_dout;
    logic e_chip;
    logic e_sym;

    function automatic void build_pn();
        logic [4:0] l;
        logic fb;
        l = 5'b00001;
        for (int i = 0; i < NCHIP; i++) begin
            pn[i] = l[0];
            fb = ^(l & 5'b00101);
            l = {fb, l[4:1]};
        end
    endfunction

    function automatic logic signed [9:0] spread(input logic b, input logic c,
                                                 input logic signed [9:0] s);
        if (b ^ c) return (s == -10'sd512) ? 10'sd511 : -s;
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, check din_ready, advance model, check registered outputs.
    task automatic cycle(input logic rn, input logic ce, input logic dv, input logic d,
                         input logic cv, input logic signed [9:0] cs, output logic rdy_seen);
        logic adv, xfer, was_idle;
        reset_n       = rn;
        clken         = ce;
        bus.din_valid = dv;
        bus.din       = d;
        bus.car_valid = cv;
        bus.car_sin   = cs;
        #3;
        exp_rdy = m_idle || (ce && cv && m_pos == NS - 1);
        if (rn) check("din_ready", bus.din_ready, exp_rdy);
        rdy_seen = bus.din_ready;
        if (!rn) begin
            m_idle = 1'b1; m_pos = 0; e_dv = 1'b0; e_dout = '0; e_chip = 1'b0; e_sym = 1'b0;
        end else begin
            adv      = ce && cv;
            xfer     = dv && exp_rdy && ce;
            was_idle = m_idle;
            e_dv     = adv;
            e_sym    = 1'b0;
            if (adv) begin
                if (was_idle) begin
                    e_dout = '0;
                    e_chip = 1'b0;
                end else begin
                    e_chip = pn[m_pos / SPC];
                    e_dout = spread(m_bit, e_chip, cs);
                    e_sym  = (m_pos == 0);
                    m_pos++;
                end
            end
            if (was_idle) begin
                if (xfer) begin m_idle = 1'b0; m_bit = d; m_pos = 0; end
            end else if (m_pos == NS) begin
                if (xfer) begin m_bit = d; m_pos = 0; end
                else m_idle = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("dout_valid", bus.dout_valid, e_dv);
        check("dout", bus.dout, e_dout);
        check("chip_o", bus.chip_o, e_chip);
        check("sym_start", bus.sym_start, e_sym);
    endtask

    // ---------------- directed first-sample table ----------------
    typedef struct {
        logic signed [9:0] car;
        logic              b;
        logic signed [9:0] exp_dout;   // first sample of symbol, PN chip 0 = 1
    } vec_t;

    vec_t vt [8];

    initial begin
        logic r;
        int nz, syms, pulses, pulse_at;
        logic signed [9:0] cs;

        build_pn();
        m_idle = 1'b1; m_pos = 0; m_bit = 1'b0;
        e_dv = 1'b0; e_dout = '0; e_chip = 1'b0; e_sym = 1'b0;
        bus.din_valid = 1'b0; bus.din = 1'b0; bus.car_valid = 1'b0; bus.car_sin = '0;

        vt[0] = '{car: 10'sd100,  b: 1'b0, exp_dout: -10'sd100};
        vt[1] = '{car: 10'sd100,  b: 1'b1, exp_dout: 10'sd100};
        vt[2] = '{car: -10'sd512, b: 1'b0, exp_dout: 10'sd511};
        vt[3] = '{car: 10'sd511,  b: 1'b0, exp_dout: -10'sd511};
        vt[4] = '{car: -10'sd512, b: 1'b1, exp_dout: -10'sd512};
        vt[5] = '{car: 10'sd0,    b: 1'b0, exp_dout: 10'sd0};
        vt[6] = '{car: -10'sd1,   b: 1'b0, exp_dout: 10'sd1};
        vt[7] = '{car: 10'sd1,    b: 1'b1, exp_dout: 10'sd1};

        @(posedge clk); #1;
        cycle(0, 1, 0, 0, 0, 0, r);
        cycle(0, 1, 0, 0, 0, 0, r);
        check("reset_din_ready", bus.din_ready, 1);

        // table: accept bit without a carrier sample, then one sample
        foreach (vt[i]) begin
            cycle(1, 1, 1, vt[i].b, 0, 0, r);
            cycle(1, 1, 0, 0, 1, vt[i].car, r);
            check("tbl_dout", bus.dout, vt[i].exp_dout);
            check("tbl_sym_start", bus.sym_start, 1);
            cycle(0, 1, 0, 0, 0, 0, r);
        end

        // single bit 0 then 1, constant carrier: 124 nonzero samples, one sym_start
        for (int b = 0; b < 2; b++) begin
            nz = 0; syms = 0;
            cycle(1, 1, 1, b[0], 1, 10'sd100, r);
            for (int k = 0; k < NS + 10; k++) begin
                cycle(1, 1, 0, 0, 1, 10'sd100, r);
                if (bus.dout_valid && bus.dout != 0) nz++;
                if (bus.sym_start) syms++;
            end
            check("single_sym_samples", nz, NS);
            check("single_sym_starts", syms, 1);
        end

        // back-to-back bits 0,1 with continuous din_valid
        pulses = 0; pulse_at = -1;
        cycle(1, 1, 1, 0, 1, 10'sd100, r);
        for (int k = 1; k <= NS; k++) begin
            cycle(1, 1, 1, 1, 1, 10'sd100, r);
            if (r) begin pulses++; pulse_at = k - 1; end
        end
        check("b2b_ready_pulses", pulses, 1);
        check("b2b_ready_index", pulse_at, NS - 1);
        cycle(1, 1, 0, 0, 1, 10'sd100, r);
        check("b2b_first_new", bus.dout, 100);
        check("b2b_sym_start", bus.sym_start, 1);
        for (int k = 0; k < NS + 4; k++) cycle(1, 1, 0, 0, 1, 10'sd100, r);

        // stalls: car_valid toggling and clken low 5 cycles mid-symbol
        nz = 0;
        cycle(1, 1, 1, 0, 0, 10'sd100, r);
        for (int k = 0; k < 2 * NS + 40; k++) begin
            cycle(1, !(k >= 100 && k < 105), 0, 0, k[0], 10'sd100, r);
            if (bus.dout_valid && bus.dout != 0) nz++;
        end
        check("stall_sym_samples", nz, NS);

        // reset at sample 50, then restart
        cycle(1, 1, 1, 0, 1, 10'sd100, r);
        for (int k = 0; k < 50; k++) cycle(1, 1, 0, 0, 1, 10'sd100, r);
        cycle(0, 1, 0, 0, 1, 10'sd100, r);
        check("rst_mid_dout_valid", bus.dout_valid, 0);
        check("rst_mid_din_ready", bus.din_ready, 1);
        cycle(1, 1, 1, 1, 0, 10'sd100, r);
        cycle(1, 1, 0, 0, 1, 10'sd100, r);
        check("rst_restart_dout", bus.dout, 100);
        check("rst_restart_sym", bus.sym_start, 1);
        for (int k = 0; k < NS + 4; k++) cycle(1, 1, 0, 0, 1, 10'sd100, r);

        // randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            cs = ($urandom % 16 == 0) ? -10'sd512 : 10'($urandom);
            cycle(1, ($urandom % 8) != 0, ($urandom % 4) == 0, 1'($urandom),
                  ($urandom % 4) != 0, cs, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsss_spread_mod.md
# dsss_spread_mod

DSSS BPSK transmitter that produces the sample stream the DsssDemod chain receives. Accepts one data bit per symbol over a valid/ready handshake, spreads it with a 31-chip m-sequence, and multiplies each chip against 10-bit two's-complement sine samples from the existing `nco` core (`fsin_o`/`out_valid`). Sits between the bit source and the DAC/channel model in the modulator-side test harness.

## Interface
- `SPC`, 4: carrier samples per chip, ≥1.
- `PN_W`, 5: LFSR width; chips per symbol = 2^PN_W−1 (31).
- `POLY`, 5'b00101: feedback taps, fb = ^(lfsr & POLY).
- `SEED`, 5'b00001: LFSR load value at every symbol start, nonzero.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `clken` in 1: global enable, same meaning as the `nco` clken.
- `din_valid` in 1: data bit offered.
- `din` in 1: data bit.
- `din_ready` out 1: block accepts `din` this cycle.
- `car_valid` in 1: carrier sample valid (`nco` out_valid).
- `car_sin` in 10: signed carrier sample (`nco` fsin_o).
- `dout_valid` out 1: output sample valid.
- `dout` out 10: signed spread-modulated sample.
- `chip_o` out 1: current chip, aligned with `dout`.
- `sym_start` out 1: high with first `dout` of each symbol.

## Operation
- States: IDLE, RUN.
- Transfer = `din_valid & din_ready & clken`.
- IDLE: `din_ready`=1. Each `car_valid&clken` emits `dout`=0, `chip_o`=0. On transfer: latch bit, LFSR←SEED, samp_cnt←0, chip_cnt←0, go RUN.
- RUN: each `car_valid&clken` emits one sample.
  - Output: `dout` = (bit ^ lfsr[0]) ? −car_sin : car_sin. Exception: −(−512) saturates to +511.
  - samp_cnt increments. On samp_cnt==SPC−1 it wraps to 0, LFSR steps, chip_cnt increments.
  - LFSR step: lfsr ← {fb, lfsr[PN_W−1:1]}.
- End of symbol is the last sample of chip 30, i.e. sample SPC−1.
  - `din_ready`=1 in RUN only during that sample's cycle (`car_valid&clken` and both counters at terminal).
  - If a transfer occurs there: latch the new bit, reload SEED, clear counters, stay RUN. There is no gap sample.
  - Otherwise go IDLE.
- `din_ready`=0 in RUN at all other times. `din_valid` is ignored then.
- `car_valid` low: counters, LFSR and state hold; no output sample.
- `clken` low: all state holds; `dout_valid`=0.
- Counter widths: samp_cnt is clog2(SPC); chip_cnt is PN_W bits.

## Timing
- Reset values: `dout_valid`=0, `dout`=0, `chip_o`=0, `sym_start`=0, `din_ready`=1, state=IDLE, LFSR=SEED, counters=0.
- Reset is sampled on `clk` rising edge. Asserting it mid-symbol aborts the symbol; the next cycle is IDLE with all outputs at reset values.
- Latency is 1 cycle: `car_valid&clken` at edge N gives `dout`/`dout_valid`/`chip_o` registered at edge N+1.
- `dout_valid` = registered (`car_valid&clken`) in both states. `dout` holds its last value when `dout_valid`=0.
- `din_ready` is combinational from state, counters, `car_valid` and `clken`.
- A transfer from IDLE at edge N puts the first RUN sample at the next `car_valid`. If `car_valid` is also high at N, that sample is the IDLE zero.
- `sym_start` is a 1-cycle pulse with `dout_valid` for chip 0, sample 0.
- Back-to-back symbols: chip 30 last sample at edge N is followed by chip 0 of the new bit at the next valid sample.
- Symbol length: 31·SPC valid carrier samples.

## Test plan
- Constant `car_sin`=100, SPC=4, `car_valid`=1, one bit `din`=0, then `din_valid`=0.
  - Chips 1,0,0,0,0,1,…: `dout` = −100×4, +100×16, −100×4, …; 124 samples total.
  - Then IDLE zeros with `dout_valid`=1; `sym_start` only on the first sample.
- Same stimulus with `din`=1: every sample sign-inverted (+100×4, −100×16, …).
- Bits 0,1 offered with continuous `din_valid`.
  - `din_ready` pulses exactly once at sample 123.
  - Sample 124 = +100 (chip 1, bit 1), `sym_start`=1; no zero gap.
- `car_sin`=−512, bit 0, chip 1 → `dout`=+511; `car_sin`=+511 → `dout`=−511.
- `car_valid` toggling 1/0, plus `clken` low for 5 cycles mid-symbol.
  - Sample sequence is identical to the continuous run, just stretched.
  - `dout_valid`=0 during stalls; the symbol still spans 124 valid samples.
- `reset_n`=0 for 1 cycle at sample 50.
  - Next cycle: IDLE, `dout_valid`=0, `din_ready`=1.
  - A new bit restarts at chip 0 with the SEED sequence.
